pe_nic_rx: RTL and testbench

- Processor-side ejection interface for one node of the 4-node ring router (router_ring_4).
- Consumes the router's PE output channel (peso/pedo), generates the pero credit, and buffers delivered 64-bit packets in a small FIFO.
- Presents the buffered packets to the local processor through a show-ahead read port.
- Maintains a delivered-packet counter and a sticky overflow flag for debug.

---
 rtl/ring_pkg.sv | 19 +
 rtl/pe_rx_fifo.sv | 54 +++++
 rtl/pe_nic_rx.sv | 82 ++++++++
 tb/tb_pe_nic_rx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared ring packet definitions used by the injection and ejection blocks.
package ring_pkg;
    localparam int PKT_W   = 64;
    localparam int VC_BIT  = 63;
    localparam int DIR_BIT = 62;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;
    localparam int SRC_MSB = 47;
    localparam int SRC_LSB = 32;
    localparam int PAY_MSB = 31;
    localparam int PAY_LSB = 0;

    typedef logic [PKT_W-1:0] pkt_t;

    // Source node id carried in a packet.
    function automatic logic [SRC_MSB-SRC_LSB:0] pkt_src(input pkt_t p);
        return p[SRC_MSB:SRC_LSB];
    endfunction
endpackage

// File: rtl/pe_rx_fifo.sv
// Show-ahead synchronous FIFO. Push/pop arrive already qualified by the
// wrapper; occupancy is tracked separately so full and empty never alias.
module pe_rx_fifo
    import ring_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  pkt_t          din,
    output pkt_t          dout,
    output logic [LW-1:0] level,
    output logic [LW-1:0] level_nxt
);
    localparam int AW = $clog2(DEPTH);

    pkt_t              mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage; a push into a full FIFO together with a pop reuses the head slot,
    // which is safe because the head is read combinationally this cycle.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout      = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign level_nxt = level_d;
endmodule

// File: rtl/pe_nic_rx.sv
// Processor-side ejection port: buffers router deliveries, returns the
// pero credit, and keeps a delivered-packet counter and sticky overflow flag.
module pe_nic_rx
    import ring_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             peso,
    input  logic [63:0]      pedo,
    output logic             pero,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [63:0]      rd_data,
    output logic [15:0]      rd_src,
    output logic             rd_vc,
    output logic [LW-1:0]    level,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             ovf,
    input  logic             clr
);
    logic             pero_q, pero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [LW-1:0]    level_nxt;
    logic             full, pop_acc, push_acc;

    // A pop frees the head first, so a push into a full FIFO is accepted with it.
    always_comb begin
        full     = (level == LW'(DEPTH));
        pop_acc  = rd_en && rd_valid;
        push_acc = peso && (!full || pop_acc);
    end

    pe_rx_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (push_acc),
        .pop       (pop_acc),
        .din       (pedo),
        .dout      (rd_data),
        .level     (level),
        .level_nxt (level_nxt)
    );

    // Credit leaves room for one packet already in flight plus one more;
    // clr takes priority over both counting and overflow capture.
    always_comb begin
        pero_d = (level_nxt <= LW'(DEPTH - 2));
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (push_acc) cnt_d = cnt_q + 1'b1;
        if (peso && !push_acc) ovf_d = 1'b1;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Credit, counter and overflow registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pero_q <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pero_q <= pero_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pero     = pero_q;
    assign rd_valid = (level != '0);
    assign rd_src   = pkt_src(rd_data);
    assign rd_vc    = rd_data[VC_BIT];
    assign pkt_cnt  = cnt_q;
    assign ovf      = ovf_q;
endmodule

// File: tb/tb_pe_nic_rx.sv
// Randomized and directed bench for pe_nic_rx against a queue-based model.
module tb_pe_nic_rx;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0, RST = 1'b0;
    logic             peso = 1'b0, rd_en = 1'b0, clr = 1'b0;
    logic [63:0]      pedo = '0;
    logic             pero, rd_valid, rd_vc, ovf;
    logic [63:0]      rd_data;
    logic [15:0]      rd_src;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] pkt_cnt;

    pe_nic_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .peso(peso), .pedo(pedo), .pero(pero),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_src(rd_src),
        .rd_vc(rd_vc), .level(level), .pkt_cnt(pkt_cnt), .ovf(ovf), .clr(clr)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0;

    // Reference model: queue of buffered packets plus debug state.
    logic [63:0] mq[$];
    int          m_cnt;
    bit          m_ovf, m_pero;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_cnt = 0; m_ovf = 0; m_pero = 0;
    endtask

    // Apply the spec's rules for one rising edge.
    task automatic m_edge(input bit p, input logic [63:0] d, input bit r, input bit c);
        bit pop_ok, push_ok;
        pop_ok  = r && (mq.size() > 0);
        push_ok = p && ((mq.size() < DEPTH) || pop_ok);
        if (pop_ok) void'(mq.pop_front());
        if (push_ok) begin
            mq.push_back(d);
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
        if (p && !push_ok) m_ovf = 1;
        if (c) begin m_cnt = 0; m_ovf = 0; end
        m_pero = (mq.size() <= DEPTH - 2);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(rd_valid), 64'(mq.size() > 0));
        chk({tag, ".level"}, 64'(level), 64'(mq.size()));
        chk({tag, ".pero"},  64'(pero), 64'(m_pero));
        chk({tag, ".cnt"},   64'(pkt_cnt), 64'(m_cnt));
        chk({tag, ".ovf"},   64'(ovf), 64'(m_ovf));
        if (mq.size() > 0) begin
            chk({tag, ".data"}, rd_data, mq[0]);
            chk({tag, ".src"},  64'(rd_src), 64'(mq[0][47:32]));
            chk({tag, ".vc"},   64'(rd_vc), 64'(mq[0][63]));
        end
    endtask

    // Called just after a falling edge: drive, clock, update model, re-check.
    task automatic cycle(input bit p, input logic [63:0] d, input bit r, input bit c,
                         input string tag);
        peso = p; pedo = d; rd_en = r; clr = c;
        @(posedge CLK);
        m_edge(p, d, r, c);
        @(negedge CLK);
        peso = 0; rd_en = 0; clr = 0;
        check_all(tag);
    endtask

    bit          allow, p_prev;
    int          acc;
    logic [63:0] exp_pay;

    initial begin
        m_reset();
        repeat (5) @(negedge CLK);
        check_all("rst");
        RST = 1'b1;
        cycle(0, '0, 0, 0, "idle");
        chk("idle.pero1", 64'(pero), 64'd1);

        // Single delivery then pop.
        cycle(1, 64'h4001_0000_1234_5678, 0, 0, "single");
        chk("single.data", rd_data, 64'h4001_0000_1234_5678);
        chk("single.cnt", 64'(pkt_cnt), 64'd1);
        cycle(0, '0, 1, 0, "single.pop");
        chk("single.empty", 64'(rd_valid), 64'd0);
        cycle(0, '0, 1, 0, "popempty");

        // Back-pressure: router obeys the previous cycle's pero.
        cycle(0, '0, 0, 1, "bp.clr");
        acc = 0; p_prev = m_pero;
        for (int i = 0; i < 20 && acc < 4; i++) begin
            allow = p_prev; p_prev = m_pero;
            if (allow) acc++;
            cycle(allow, 64'(allow ? acc : 0), 0, 0, "bp.fill");
            if (mq.size() == 3) chk("bp.pero_at3", 64'(pero), 64'd0);
        end
        chk("bp.acc", 64'(acc), 64'd4);
        repeat (3) cycle(0, '0, 0, 0, "bp.hold");
        chk("bp.level", 64'(level), 64'd4);
        chk("bp.ovf", 64'(ovf), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            chk("bp.order", 64'(rd_data[31:0]), 64'(i));
            cycle(0, '0, 1, 0, "bp.pop");
        end

        // Streaming: push and pop every cycle.
        cycle(0, '0, 0, 1, "st.clr");
        exp_pay = 1;
        for (int k = 1; k <= 21; k++) begin
            if (rd_valid) begin
                chk("st.order", 64'(rd_data[31:0]), exp_pay);
                exp_pay++;
            end
            cycle(k <= 20, 64'(k <= 20 ? k : 0), 1, 0, "st");
            chk("st.lvl_le1", 64'(level <= 1), 64'd1);
            chk("st.pero", 64'(pero), 64'd1);
        end
        chk("st.count", 64'(exp_pay - 1), 64'd20);
        chk("st.cnt", 64'(pkt_cnt), 64'd20);

        // Protocol violation: fifth packet into a full FIFO.
        cycle(0, '0, 0, 1, "ov.clr");
        for (int k = 1; k <= 4; k++) cycle(1, 64'(k), 0, 0, "ov.fill");
        cycle(1, 64'd5, 0, 0, "ov.push5");
        chk("ov.ovf", 64'(ovf), 64'd1);
        chk("ov.cnt", 64'(pkt_cnt), 64'd4);
        cycle(0, '0, 0, 1, "ov.clr2");
        chk("ov.clr_ovf", 64'(ovf), 64'd0);
        chk("ov.clr_lvl", 64'(level), 64'd4);
        for (int k = 1; k <= 4; k++) begin
            chk("ov.order", 64'(rd_data[31:0]), 64'(k));
            cycle(0, '0, 1, 0, "ov.drain");
        end

        // Random traffic, mostly protocol-obeying with occasional violations.
        p_prev = m_pero;
        for (int i = 0; i < 400; i++) begin
            bit p;
            allow = p_prev; p_prev = m_pero;
            p = ($urandom_range(0, 9) < 6) && (allow || ($urandom_range(0, 15) == 0));
            cycle(p, {$urandom, $urandom}, $urandom_range(0, 9) < 4,
                  $urandom_range(0, 31) == 0, "rnd");
        end

        // Async reset with three packets buffered.
        for (int i = 0; i < 8 && mq.size() > 0; i++) cycle(0, '0, 1, 0, "ar.drain");
        chk("ar.empty", 64'(mq.size()), 64'd0);
        for (int k = 0; k < 3; k++) cycle(1, {$urandom, $urandom}, 0, 0, "ar.fill");
        chk("ar.level3", 64'(level), 64'd3);
        #2 RST = 1'b0;
        #1;
        chk("ar.valid", 64'(rd_valid), 64'd0);
        chk("ar.pero", 64'(pero), 64'd0);
        chk("ar.level", 64'(level), 64'd0);
        m_reset();
        @(negedge CLK);
        check_all("ar.held");
        RST = 1'b1;
        cycle(0, '0, 0, 0, "ar.release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
